pipe_fetch: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register. It feeds the decode stage with `dpc4`/`inst` and takes back that stage's `pcsource`, branch/jump targets, `wpcir` (ID advance) and `djflush`. It owns the PC and drives a single-outstanding, variable-latency instruction-memory request/ready interface. A one-entry fetch buffer decouples memory latency from decode stalls.

---
 rtl/pipe_fetch.sv | 178 +++++++++++++++++
 tb/tb_pipe_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage with IF/ID register, single-outstanding imem requests and a
// one-entry fetch buffer that absorbs a response while decode is stalled.
module pipe_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    input  logic        wpcir,
    input  logic        djflush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {StIdle, StBusy, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] dpc4_q, dpc4_d;

    logic        redirect;
    logic [31:0] target;
    logic        rsp_valid;
    logic        deliver;
    logic        space_now;
    logic        space_after;
    logic        issue;
    logic [31:0] issue_addr;

    always_comb begin
        redirect = wpcir & (pcsource != 2'b00);
        unique case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = ra;
            2'b11:   target = jpc;
            default: target = pc_q;
        endcase
        // A strobe with no request outstanding belongs to nobody.
        rsp_valid = imem_ready & req_q;
        deliver   = (state_q == StBusy) & rsp_valid & ~redirect;
    end

    // IF/ID register and fetch buffer.
    always_comb begin
        inst_d      = inst_q;
        dpc4_d      = dpc4_q;
        buf_valid_d = buf_valid_q;
        buf_inst_d  = buf_inst_q;
        buf_pc4_d   = buf_pc4_q;
        if (wpcir) begin
            if (redirect || djflush) begin
                inst_d      = NOP_INST;
                dpc4_d      = 32'h0;
                buf_valid_d = 1'b0;
            end else if (buf_valid_q) begin
                inst_d      = buf_inst_q;
                dpc4_d      = buf_pc4_q;
                buf_valid_d = deliver;
                if (deliver) begin
                    buf_inst_d = imem_rdata;
                    buf_pc4_d  = addr_q + 32'd4;
                end
            end else if (deliver) begin
                inst_d = imem_rdata;
                dpc4_d = addr_q + 32'd4;
            end else begin
                inst_d = NOP_INST;
                dpc4_d = 32'h0;
            end
        end else if (deliver) begin
            buf_valid_d = 1'b1;
            buf_inst_d  = imem_rdata;
            buf_pc4_d   = addr_q + 32'd4;
        end
    end

    // Request sequencing and PC.
    always_comb begin
        space_now   = ~buf_valid_q | wpcir;
        space_after = ~buf_valid_d;
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        issue       = 1'b0;
        issue_addr  = pc_q;
        case (state_q)
            StIdle: begin
                if (redirect || space_now) begin
                    issue      = 1'b1;
                    issue_addr = redirect ? target : pc_q;
                end
            end
            StBusy: begin
                if (rsp_valid) begin
                    if (redirect) begin
                        issue      = 1'b1;
                        issue_addr = target;
                    end else if (space_after) begin
                        issue = 1'b1;
                    end else begin
                        state_d = StIdle;
                        req_d   = 1'b0;
                    end
                end else if (redirect) begin
                    pc_d    = target;
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (redirect) begin
                    pc_d = target;
                end
                // The buffer is always empty here: entering DROP required a redirect.
                if (rsp_valid) begin
                    issue      = 1'b1;
                    issue_addr = redirect ? target : pc_q;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
        if (issue) begin
            state_d = StBusy;
            req_d   = 1'b1;
            addr_d  = issue_addr;
            pc_d    = issue_addr + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= 32'h0;
            buf_valid_q <= 1'b0;
            buf_inst_q  <= NOP_INST;
            buf_pc4_q   <= 32'h0;
            inst_q      <= NOP_INST;
            dpc4_q      <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            buf_valid_q <= buf_valid_d;
            buf_inst_q  <= buf_inst_d;
            buf_pc4_q   <= buf_pc4_d;
            inst_q      <= inst_d;
            dpc4_q      <= dpc4_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign inst      = inst_q;
    assign dpc4      = dpc4_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_pipe_fetch.sv
// Bench for pipe_fetch: directed scenarios with exact cycle expectations, then random
// stalls/redirects/latency checked against a program-order stream model.
module tb_pipe_fetch;

    logic        clock;
    logic        resetn, resetn1;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, ra;
    logic        wpcir, djflush;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] dpc4, inst, pc;

    logic        imem_req1, imem_ready1;
    logic [31:0] imem_addr1, imem_rdata1;
    logic [31:0] dpc4_1, inst1, pc1;

    int          n_checks, n_errors;
    int          mem_mode;  // 0 always ready, 1 never ready, 2 random
    logic [31:0] key;

    pipe_fetch dut (
        .clock     (clock),
        .resetn    (resetn),
        .pcsource  (pcsource),
        .bpc       (bpc),
        .jpc       (jpc),
        .ra        (ra),
        .wpcir     (wpcir),
        .djflush   (djflush),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .dpc4      (dpc4),
        .inst      (inst),
        .pc        (pc)
    );

    pipe_fetch #(.RESET_PC(32'hFFFF_FFF8), .NOP_INST(32'h0000_0000)) dut_wrap (
        .clock     (clock),
        .resetn    (resetn1),
        .pcsource  (2'b00),
        .bpc       (32'h0),
        .jpc       (32'h0),
        .ra        (32'h0),
        .wpcir     (1'b1),
        .djflush   (1'b0),
        .imem_req  (imem_req1),
        .imem_addr (imem_addr1),
        .imem_ready(imem_ready1),
        .imem_rdata(imem_rdata1),
        .dpc4      (dpc4_1),
        .inst      (inst1),
        .pc        (pc1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive_mem();
        case (mem_mode)
            0: begin
                imem_ready = 1'b1;
                imem_rdata = imem_addr ^ key;
            end
            1: begin
                imem_ready = 1'b0;
                imem_rdata = $urandom;
            end
            default: begin
                imem_ready = 1'($urandom_range(0, 1));
                imem_rdata = imem_req ? (imem_addr ^ key) : $urandom;
            end
        endcase
        imem_ready1 = 1'b1;
        imem_rdata1 = imem_addr1;
    endtask

    // One clock; outputs are sampled and inputs driven on the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        drive_mem();
    endtask

    task automatic expect_ifid(input string tag, input logic [31:0] e_inst,
                               input logic [31:0] e_dpc4);
        check_eq({tag, ".inst"}, inst, e_inst);
        check_eq({tag, ".dpc4"}, dpc4, e_dpc4);
    endtask

    logic [31:0] exp_addr, tgt;
    logic        p_w, p_r, p_ready, p_req;
    logic [31:0] p_addr, p_inst, p_dpc4;
    int          delivered;

    initial begin
        n_checks = 0;
        n_errors = 0;
        key      = 32'h0;
        mem_mode = 0;
        resetn   = 1'b0;
        resetn1  = 1'b0;
        wpcir    = 1'b1;
        djflush  = 1'b0;
        pcsource = 2'b00;
        bpc      = 32'h0;
        jpc      = 32'h0;
        ra       = 32'h0;
        drive_mem();

        // Reset and startup
        repeat (3) tick();
        check_eq("rst.req", {31'h0, imem_req}, 32'h0);
        check_eq("rst.addr", imem_addr, 32'h0);
        check_eq("rst.pc", pc, 32'h0);
        expect_ifid("rst", 32'h0, 32'h0);
        resetn = 1'b1;
        tick();
        check_eq("start.req", {31'h0, imem_req}, 32'h1);
        check_eq("start.addr", imem_addr, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_ifid("stream", 32'(4 * k), 32'(4 * k + 4));
        end

        // Decode stall with inst=0x8 in IF/ID
        wpcir = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_ifid("stall", 32'h8, 32'hC);
            check_eq("stall.req", {31'h0, imem_req}, 32'h0);
            check_eq("stall.pc", pc, 32'h10);
        end
        wpcir = 1'b1;
        tick();
        expect_ifid("unstall0", 32'hC, 32'h10);
        check_eq("unstall.addr", imem_addr, 32'h10);
        tick();
        expect_ifid("unstall1", 32'h10, 32'h14);

        // Branch at inst=0x10
        pcsource = 2'b01;
        bpc      = 32'h40;
        tick();
        pcsource = 2'b00;
        expect_ifid("br.bubble", 32'h0, 32'h0);
        check_eq("br.addr", imem_addr, 32'h40);
        tick();
        expect_ifid("br.t0", 32'h40, 32'h44);
        tick();
        expect_ifid("br.t1", 32'h44, 32'h48);

        // Slow memory: redirects while a request is outstanding
        mem_mode = 1;
        drive_mem();
        tick();
        check_eq("slow.req", {31'h0, imem_req}, 32'h1);
        check_eq("slow.addr", imem_addr, 32'h48);
        expect_ifid("slow", 32'h0, 32'h0);
        pcsource = 2'b11;
        jpc      = 32'h80;
        tick();
        check_eq("drop.addr", imem_addr, 32'h48);
        check_eq("drop.pc0", pc, 32'h80);
        pcsource = 2'b10;
        ra       = 32'h100;
        tick();
        check_eq("drop.pc1", pc, 32'h100);
        pcsource = 2'b01;
        bpc      = 32'h200;
        tick();
        pcsource = 2'b00;
        check_eq("drop.pc2", pc, 32'h200);
        check_eq("drop.addr2", imem_addr, 32'h48);
        tick();
        check_eq("drop.req", {31'h0, imem_req}, 32'h1);
        mem_mode = 0;
        drive_mem();
        tick();
        check_eq("drain.addr", imem_addr, 32'h200);
        expect_ifid("drain", 32'h0, 32'h0);
        tick();
        expect_ifid("drain.t0", 32'h200, 32'h204);
        tick();
        expect_ifid("drain.t1", 32'h204, 32'h208);

        // djflush without redirect squashes the arriving instruction
        djflush = 1'b1;
        tick();
        djflush = 1'b0;
        expect_ifid("flush", 32'h0, 32'h0);
        check_eq("flush.addr", imem_addr, 32'h20C);
        tick();
        expect_ifid("flush.next", 32'h20C, 32'h210);

        // Random phase: stream must follow program order from each redirect target
        key      = 32'h5A5A_5A5A;
        mem_mode = 2;
        pcsource = 2'b11;
        jpc      = 32'h1000;
        drive_mem();
        tick();
        pcsource = 2'b00;
        expect_ifid("rnd.start", 32'h0, 32'h0);
        exp_addr  = 32'h1000;
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            wpcir    = ($urandom_range(0, 3) != 0);
            pcsource = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bpc      = $urandom & 32'h000F_FFFC;
            jpc      = $urandom & 32'h000F_FFFC;
            ra       = $urandom & 32'h000F_FFFC;
            p_w      = wpcir;
            p_r      = wpcir && (pcsource != 2'b00);
            tgt      = (pcsource == 2'b01) ? bpc : (pcsource == 2'b10) ? ra : jpc;
            p_ready  = imem_ready;
            p_req    = imem_req;
            p_addr   = imem_addr;
            p_inst   = inst;
            p_dpc4   = dpc4;
            tick();
            if (p_req && !p_ready) begin
                check_eq("rnd.req_hold", {31'h0, imem_req}, 32'h1);
                check_eq("rnd.addr_hold", imem_addr, p_addr);
            end
            if (!p_w) begin
                expect_ifid("rnd.stall", p_inst, p_dpc4);
            end else if (p_r) begin
                expect_ifid("rnd.redirect", 32'h0, 32'h0);
                exp_addr = tgt;
            end else if (!(inst == 32'h0 && dpc4 == 32'h0)) begin
                expect_ifid("rnd.order", exp_addr ^ key, exp_addr + 32'd4);
                exp_addr = exp_addr + 32'd4;
                delivered++;
            end
        end
        pcsource = 2'b00;
        wpcir    = 1'b1;
        check_eq("rnd.progress", {31'h0, delivered > 100}, 32'h1);

        // Wrap-around and mid-operation reset on the second instance
        resetn1 = 1'b1;
        tick();
        check_eq("wrap.addr0", imem_addr1, 32'hFFFF_FFF8);
        tick();
        check_eq("wrap.inst0", inst1, 32'hFFFF_FFF8);
        check_eq("wrap.dpc0", dpc4_1, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap.inst1", inst1, 32'hFFFF_FFFC);
        check_eq("wrap.dpc1", dpc4_1, 32'h0);
        check_eq("wrap.addr2", imem_addr1, 32'h0);
        tick();
        check_eq("wrap.inst2", inst1, 32'h0);
        check_eq("wrap.dpc2", dpc4_1, 32'h4);
        resetn1 = 1'b0;
        tick();
        check_eq("mrst.req", {31'h0, imem_req1}, 32'h0);
        check_eq("mrst.inst", inst1, 32'h0);
        check_eq("mrst.dpc4", dpc4_1, 32'h0);
        check_eq("mrst.pc", pc1, 32'hFFFF_FFF8);
        resetn1 = 1'b1;
        tick();
        check_eq("mrst.req1", {31'h0, imem_req1}, 32'h1);
        check_eq("mrst.addr1", imem_addr1, 32'hFFFF_FFF8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
